light_pen_capture: RTL and testbench

Converts the raw light-pen photodiode input into a single-cycle, pixel-aligned write strobe `we` for `led_driver`. Sits directly upstream of `led_driver`, alongside `scan_driver`. It watches the one-hot scan position (`led_row`/`led_col`) and the synchronized pen input. It asserts `we` only when the pen sees light steadily while one pixel is lit, so the display RAM write lands on the pixel under the pen.

---
 rtl/light_pen_capture.sv | 102 ++++++++++
 tb/tb_light_pen_capture.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/light_pen_capture.sv
// Light-pen hit detector: synchronizes the photodiode, waits out LED settle after each
// scan-position change, then emits a one-cycle write strobe once the pen sees steady light.
module light_pen_capture #(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 8,
    parameter int HIT_CYCLES    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pen_in,
    input  logic       pen_en,
    input  logic [7:0] led_row,
    input  logic [7:0] led_col,
    output logic       we,
    output logic [2:0] hit_row,
    output logic [2:0] hit_col,
    output logic       hit_valid
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, HOLD} state_t;

    state_t                 r_state;
    logic [7:0]             r_cnt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [15:0]            r_pos_q;

    logic        w_pen_s;
    logic [15:0] w_pos;
    logic        w_pos_chg;
    logic        w_pos_ok;

    assign w_pen_s   = r_sync[SYNC_STAGES-1];
    assign w_pos     = {led_row, led_col};
    assign w_pos_chg = (w_pos != r_pos_q);
    assign w_pos_ok  = $onehot(led_row) && $onehot(led_col);

    function automatic logic [2:0] onehot_to_bin(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++)
            if (v[i]) idx = 3'(i);
        return idx;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '0;
            r_pos_q <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], pen_in};
            r_pos_q <= w_pos;
        end
    end

    // Priority: pen disabled, leaving IDLE, position change/invalid, then per-state work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            we        <= 1'b0;
            hit_row   <= '0;
            hit_col   <= '0;
            hit_valid <= 1'b0;
        end else begin
            we <= 1'b0;
            if (!pen_en) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else if (r_state == IDLE || w_pos_chg || !w_pos_ok) begin
                r_state <= SETTLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    SETTLE: begin
                        if (r_cnt == 8'(SETTLE_CYCLES - 1)) begin
                            r_state <= SAMPLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    SAMPLE: begin
                        if (!w_pen_s) begin
                            r_cnt <= '0;
                        end else if (r_cnt == 8'(HIT_CYCLES - 1)) begin
                            r_state   <= HOLD;
                            r_cnt     <= '0;
                            we        <= 1'b1;
                            hit_row   <= onehot_to_bin(led_row);
                            hit_col   <= onehot_to_bin(led_col);
                            hit_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_light_pen_capture.sv
// Bench for light_pen_capture: directed scenarios plus randomized scan/pen traffic,
// checked every cycle against a history-based model of when a hit must occur.
module tb_light_pen_capture;
    localparam int SYNC = 2, SET = 8, HIT = 4;

    logic       clk = 1'b0, rst = 1'b0, pen_in = 1'b0, pen_en = 1'b0;
    logic [7:0] led_row = '0, led_col = '0;
    logic       we, hit_valid;
    logic [2:0] hit_row, hit_col;

    light_pen_capture #(.SYNC_STAGES(SYNC), .SETTLE_CYCLES(SET), .HIT_CYCLES(HIT)) dut (
        .clk(clk), .rst(rst), .pen_in(pen_in), .pen_en(pen_en),
        .led_row(led_row), .led_col(led_col),
        .we(we), .hit_row(hit_row), .hit_col(hit_col), .hit_valid(hit_valid));

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    // Model: a hit happens at cycle t when nothing restarted the pixel since cycle m_s,
    // the settle window has passed, and pen_s has been high for the last HIT cycles
    // entirely inside the sample window, once per visit.
    logic [3:0]  m_ph;
    logic [15:0] m_prev_pos;
    logic        m_prev_en;
    int          t = 0, m_s, m_run, run_t, we_cnt = 0, we_t = 0;
    bit          m_done, m_restart, m_hit;
    logic        e_we, e_valid;
    logic [2:0]  e_row, e_col;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, t);
        end
    endtask

    function automatic logic [2:0] enc(input logic [7:0] v);
        for (int i = 0; i < 8; i++)
            if (v[i]) return 3'(i);
        return 3'd0;
    endfunction

    task automatic model_reset();
        m_ph = '0; m_prev_pos = '0; m_prev_en = 1'b0; m_s = t; m_run = 0; m_done = 0;
        e_we = 0; e_row = '0; e_col = '0; e_valid = 0;
    endtask

    task automatic model_eval();
        run_t = m_ph[SYNC-1] ? m_run + 1 : 0;
        m_restart = !pen_en || !m_prev_en || ({led_row, led_col} != m_prev_pos) ||
                    ($countones(led_row) != 1) || ($countones(led_col) != 1);
        m_hit = !m_restart && !m_done && (run_t >= HIT) && ((t - m_s - SET) >= HIT);
    endtask

    task automatic model_commit();
        if (m_restart) begin m_s = t; m_done = 0; end
        if (m_hit) begin m_done = 1; e_row = enc(led_row); e_col = enc(led_col); e_valid = 1; end
        e_we = m_hit;
        m_run = run_t;
        m_prev_pos = {led_row, led_col};
        m_prev_en = pen_en;
        m_ph = {m_ph[2:0], pen_in};
        t++;
    endtask

    task automatic cyc(input logic en, input logic pin, input logic [7:0] r, input logic [7:0] c);
        @(negedge clk);
        pen_en = en; pen_in = pin; led_row = r; led_col = c;
        model_eval();
        @(posedge clk);
        model_commit();
        #1;
        chk("we", int'(we), int'(e_we));
        chk("hit_row", int'(hit_row), int'(e_row));
        chk("hit_col", int'(hit_col), int'(e_col));
        chk("hit_valid", int'(hit_valid), int'(e_valid));
        if (we) begin we_cnt++; we_t = t; end
    endtask

    // Asserted mid-cycle, held across one edge, released before the next.
    task automatic do_rst();
        #2 rst = 1'b1;
        #1;
        chk("rst_we", int'(we), 0);
        chk("rst_row", int'(hit_row), 0);
        chk("rst_col", int'(hit_col), 0);
        chk("rst_valid", int'(hit_valid), 0);
        model_reset();
        @(posedge clk);
        #1 chk("rst_hold_we", int'(we), 0);
        #1 rst = 1'b0;
    endtask

    int base, w0;
    logic [7:0] rr, cc;
    logic en_r, pin_r;
    int mode, dwell, pst;

    initial begin
        rst = 1'b1;
        #3;
        chk("init_we", int'(we), 0);
        chk("init_valid", int'(hit_valid), 0);
        chk("init_row", int'(hit_row), 0);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;

        // Pen disabled over a full frame: never a write.
        w0 = we_cnt;
        for (int p = 0; p < 64; p++)
            for (int k = 0; k < 14; k++)
                cyc(1'b0, 1'b1, 8'(1 << (p / 8)), 8'(1 << (p % 8)));
        chk("t4_no_we", we_cnt - w0, 0);
        chk("t4_valid", int'(hit_valid), 0);

        // Steady pixel (3,5), pen_s already high.
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 8'h00, 8'h00);
        base = t; w0 = we_cnt;
        for (int k = 0; k < 40; k++) cyc(1'b1, 1'b1, 8'h08, 8'h20);
        chk("t1_count", we_cnt - w0, 1);
        chk("t1_at", we_t - base, 13);
        chk("t1_row", int'(hit_row), 3);
        chk("t1_col", int'(hit_col), 5);
        chk("t1_valid", int'(hit_valid), 1);

        // One dark sample restarts the hit count.
        cyc(1'b0, 1'b1, 8'h08, 8'h20);
        base = t; w0 = we_cnt;
        for (int k = 0; k < 30; k++) cyc(1'b1, (k != 10), 8'h08, 8'h20);
        chk("t2_count", we_cnt - w0, 1);
        chk("t2_at", we_t - base, 17);

        // Pixel changes exactly on the would-be hit cycle.
        cyc(1'b0, 1'b1, 8'h08, 8'h20);
        base = t; w0 = we_cnt;
        for (int k = 0; k < 32; k++) begin
            if (k < 12) cyc(1'b1, 1'b1, 8'h02, 8'h40);
            else        cyc(1'b1, 1'b1, 8'h80, 8'h01);
            if (k == 12) begin
                chk("t3_no_we", int'(we), 0);
                chk("t3_row_kept", int'(hit_row), 3);
                chk("t3_col_kept", int'(hit_col), 5);
            end
        end
        chk("t3_count", we_cnt - w0, 1);
        chk("t3_at", we_t - base, 25);
        chk("t3_row", int'(hit_row), 7);
        chk("t3_col", int'(hit_col), 0);

        // Non-one-hot columns suppress writes; a valid code recovers.
        w0 = we_cnt;
        for (int k = 0; k < 20; k++) cyc(1'b1, 1'b1, 8'h08, 8'h00);
        for (int k = 0; k < 20; k++) cyc(1'b1, 1'b1, 8'h08, 8'h03);
        chk("t5_bad_pos", we_cnt - w0, 0);
        base = t;
        for (int k = 0; k < 20; k++) cyc(1'b1, 1'b1, 8'h08, 8'h20);
        chk("t5_count", we_cnt - w0, 1);
        chk("t5_at", we_t - base, 13);

        // Reset during SAMPLE, then reset in the hit cycle.
        cyc(1'b0, 1'b1, 8'h00, 8'h00);
        w0 = we_cnt;
        for (int k = 0; k < 10; k++) cyc(1'b1, 1'b1, 8'h10, 8'h04);
        do_rst();
        for (int k = 0; k < 12; k++) cyc(1'b1, 1'b1, 8'h10, 8'h04);
        do_rst();
        chk("t6_no_we", we_cnt - w0, 0);
        base = t;
        for (int k = 0; k < 20; k++) cyc(1'b1, 1'b1, 8'h10, 8'h04);
        chk("t6_count", we_cnt - w0, 1);
        chk("t6_at", we_t - base, 13);
        chk("t6_row", int'(hit_row), 4);
        chk("t6_col", int'(hit_col), 2);

        // Random scan traffic.
        for (int p = 0; p < 160; p++) begin
            mode = int'($urandom_range(0, 9));
            if (mode == 0) begin
                rr = 8'($urandom); cc = 8'($urandom);
            end else begin
                rr = 8'(1 << $urandom_range(0, 7)); cc = 8'(1 << $urandom_range(0, 7));
            end
            en_r  = ($urandom_range(0, 9) != 0);
            pst   = int'($urandom_range(0, 2));
            dwell = int'($urandom_range(4, 24));
            for (int k = 0; k < dwell; k++) begin
                case (pst)
                    0:       pin_r = 1'b1;
                    1:       pin_r = 1'($urandom);
                    default: pin_r = ($urandom_range(0, 7) != 0);
                endcase
                cyc(en_r, pin_r, rr, cc);
            end
            if ($urandom_range(0, 29) == 0) do_rst();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
